uart_tx_dev: RTL



---
 rtl/uart_tx_dev.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_dev.sv
// uart_tx_dev -- memory-mapped 8N1 UART transmitter for the bridge device bus.
//
// CPU stores to DATA are queued in a small byte FIFO. The transmitter
// serialises the queued bytes onto txd, LSB first, with one start bit and
// one stop bit. A level IRQ is raised once the FIFO has drained and the
// line has gone idle.
//
// Register map (byte offset, selected by Addr[3:2]):
//   0x0 DATA   : write pushes DataI[7:0]; reads 0
//   0x4 STATUS : {27'b0, ovf, busy, empty, full, 1'b0}; any write clears ovf
//   0x8 CTRL   : {irq_en, tx_en} in bits [1:0]
//   0xC DIV    : bits [15:0]; bit period = DIV+1 clocks
//
// Optional build macro UART_TX_PARITY_EN:
//   defined   -> CTRL bit2 = parity_odd; a parity bit (^byte ^ parity_odd)
//                is inserted between the data bits and the stop bit.
//   undefined -> CTRL bit2 reads 0 and ignores writes; plain 8N1 frames.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   Addr   in   [3:2] register select from the bridge
//   WE     in   write enable from the bridge
//   DataI  in   [31:0] write data
//   DataO  out  [31:0] read data, combinational on Addr
//   IRQ    out  level interrupt request (registered)
//   txd    out  serial output, idle high (registered)
module uart_tx_dev #(
  parameter int          FIFO_AW  = 3,
  parameter logic [15:0] DIV_INIT = 16'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] DataI,
  output logic [31:0] DataO,
  output logic        IRQ,
  output logic        txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   COUNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   COUNT_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   COUNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
`endif

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [2:0]         ctrl_r;
  logic [15:0]        div_r;
  logic               ovf_r;
  state_t             state_r, state_nxt_s;
  logic [7:0]         shift_r;
  logic [15:0]        period_r, baud_r;
  logic [2:0]         bitcnt_r;
  logic               txd_r, irq_r;

  logic       full_s, empty_s, busy_s, push_req_s, push_s, pop_s, bit_end_s;
  logic       txd_nxt_s, last_bit_s;
  logic [2:0] bit_nxt_s;
  logic       unused_s;

  assign unused_s = ^DataI[31:16];
  assign txd      = txd_r;
  assign IRQ      = irq_r;

  // Bus decode, FIFO flags (pre-edge count) and bit-cell timing
  always_comb begin
    full_s     = (count_r == COUNT_FULL);
    empty_s    = (count_r == COUNT_ZERO);
    busy_s     = (state_r != ST_IDLE);
    push_req_s = WE && (Addr == 2'd0);
    push_s     = push_req_s && !full_s;
    // Pop only from IDLE; a byte pushed this cycle is not yet visible here.
    pop_s      = (state_r == ST_IDLE) && ctrl_r[0] && !empty_s;
    bit_end_s  = (baud_r == period_r);
    bit_nxt_s  = bitcnt_r + 3'd1;
`ifdef UART_TX_PARITY_EN
    last_bit_s = parity_bit(shift_r, ctrl_r[2]);
`else
    last_bit_s = 1'b1;
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (pop_s) state_nxt_s = ST_START; else state_nxt_s = ST_IDLE;
      ST_START: if (bit_end_s) state_nxt_s = ST_DATA; else state_nxt_s = ST_START;
      ST_DATA: begin
        if (bit_end_s && (bitcnt_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: if (bit_end_s) state_nxt_s = ST_STOP; else state_nxt_s = ST_PARITY;
      ST_STOP:   if (bit_end_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_STOP;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: value txd takes after the coming edge
  always_comb begin
    txd_nxt_s = txd_r;
    case (state_r)
      ST_IDLE:  if (pop_s) txd_nxt_s = 1'b0; else txd_nxt_s = 1'b1;
      ST_START: if (bit_end_s) txd_nxt_s = shift_r[0]; else txd_nxt_s = 1'b0;
      ST_DATA: begin
        if (!bit_end_s) begin
          txd_nxt_s = shift_r[bitcnt_r];
        end else if (bitcnt_r == 3'd7) begin
          // After bit 7 comes the parity bit if built in, else the stop bit.
          txd_nxt_s = last_bit_s;
        end else begin
          txd_nxt_s = shift_r[bit_nxt_s];
        end
      end
      ST_PARITY: if (bit_end_s) txd_nxt_s = 1'b1; else txd_nxt_s = txd_r;
      ST_STOP:   txd_nxt_s = 1'b1;
      default:   txd_nxt_s = 1'b1;
    endcase
  end

  // Register readback, combinational on Addr
  always_comb begin
    DataO = 32'd0;
    case (Addr)
      2'd0:    DataO = 32'd0;
      2'd1:    DataO = {27'd0, ovf_r, busy_s, empty_s, full_s, 1'b0};
      2'd2:    DataO = {29'd0, ctrl_r};
      2'd3:    DataO = {16'd0, div_r};
      default: DataO = 32'd0;
    endcase
  end

  // State register with bit timer, latched frame byte/period and txd
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      txd_r    <= 1'b1;
      shift_r  <= 8'd0;
      period_r <= 16'd0;
      baud_r   <= 16'd0;
      bitcnt_r <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      txd_r   <= txd_nxt_s;
      if (pop_s) begin
        // Period is latched per frame so DIV writes only affect later frames.
        shift_r  <= mem_r[rd_ptr_r];
        period_r <= div_r;
        baud_r   <= 16'd0;
        bitcnt_r <= 3'd0;
      end else if (busy_s) begin
        if (bit_end_s) begin
          baud_r <= 16'd0;
          if (state_r == ST_DATA) begin
            bitcnt_r <= bit_nxt_s;
          end
        end else begin
          baud_r <= baud_r + 16'd1;
        end
      end
    end
  end

  // FIFO pointers/count, control registers, overflow flag and IRQ
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= COUNT_ZERO;
      ctrl_r   <= 3'd0;
      div_r    <= DIV_INIT;
      ovf_r    <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (push_s && !pop_s) begin
        count_r <= count_r + COUNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - COUNT_ONE;
      end
      // Full is judged on the pre-edge count, so a same-cycle pop does not
      // rescue a push into a full FIFO.
      if (push_req_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (WE && (Addr == 2'd1)) begin
        ovf_r <= 1'b0;
      end
      if (WE && (Addr == 2'd2)) ctrl_r <= DataI[2:0] & CTRL_MASK;
      if (WE && (Addr == 2'd3)) div_r  <= DataI[15:0];
      // Sampled from the settled registers, so IRQ lags its conditions by one clock.
      irq_r <= ctrl_r[1] && empty_s && !busy_s;
    end
  end

  // FIFO storage; contents are only meaningful under count_r, so no reset
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= DataI[7:0];
  end

endmodule
